fc_align_sequencer: RTL and testbench

//  Supervises the fast-command decoder alignment loop on clk40. Issues fccAlign pulses, waits for
//  a stable 'aligned', and re-aligns on loss of lock or invalid-command bursts. Retries in

---
 rtl/fc_align_sequencer_if.sv | 19 +
 rtl/fc_align_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fc_align_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fc_align_sequencer_if.sv
// Link between the alignment sequencer and the fast-command decoder top.
interface fc_align_sequencer_if;
  logic fccAlign;
  logic selfAlignEn;
  logic clkDelayEn;
  logic fcDelayEn;
  logic aligned;
  logic invalidCmd;

  modport master (
    output fccAlign, selfAlignEn, clkDelayEn, fcDelayEn,
    input  aligned, invalidCmd
  );

  modport slave (
    input  fccAlign, selfAlignEn, clkDelayEn, fcDelayEn,
    output aligned, invalidCmd
  );
endinterface

// File: rtl/fc_align_sequencer.sv
// Fast-command decoder alignment supervisor: pulses fccAlign, waits for a stable lock,
// retries in self-align mode, then scans the four manual delay settings before giving up.
module fc_align_sequencer #(
  parameter int unsigned PULSE_LEN    = 4,
  parameter int unsigned SETTLE       = 64,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned ERR_WINDOW   = 4096,
  parameter int unsigned ERR_THRESH   = 4
) (
  input  logic                 clk40,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 forceRealign,
  fc_align_sequencer_if.master dec,
  output logic                 locked,
  output logic                 failed,
  output logic [2:0]           state,
  output logic [1:0]           retryCnt,
  output logic [7:0]           errCnt
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PULSE     = 3'd1;
  localparam logic [2:0] WAIT_LOCK = 3'd2;
  localparam logic [2:0] LOCKED    = 3'd3;
  localparam logic [2:0] FAILED    = 3'd4;

  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int WW = $clog2(ERR_WINDOW + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);

  localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_LEN - 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [WW-1:0] WINDOW_LAST  = WW'(ERR_WINDOW - 1);
  localparam logic [EW-1:0] THRESH_LAST  = EW'(ERR_THRESH - 1);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

  logic          fcc_align;
  logic          self_align_en;
  logic [1:0]    manual_setting;
  logic [PW-1:0] pulse_cnt;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] timer;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  logic          aligned;
  logic          invalid_cmd;
  logic          err_hit;
  logic          win_wrap;

  assign dec.fccAlign    = fcc_align;
  assign dec.selfAlignEn = self_align_en;
  assign dec.clkDelayEn  = manual_setting[1];
  assign dec.fcDelayEn   = manual_setting[0];
  assign aligned         = dec.aligned;
  assign invalid_cmd     = dec.invalidCmd;

  // The invalidCmd that lands on the threshold counts even in the last cycle of a window.
  assign err_hit  = invalid_cmd && (win_err == THRESH_LAST);
  assign win_wrap = (win_cnt == WINDOW_LAST);

  always_ff @(posedge clk40) begin
    if (reset) begin
      state          <= IDLE;
      fcc_align      <= 1'b0;
      self_align_en  <= 1'b1;
      manual_setting <= 2'b00;
      locked         <= 1'b0;
      failed         <= 1'b0;
      retryCnt       <= 2'd0;
      errCnt         <= 8'd0;
      pulse_cnt      <= '0;
      settle_cnt     <= '0;
      timer          <= '0;
      win_cnt        <= '0;
      win_err        <= '0;
    end else if (!enable) begin
      state          <= IDLE;
      fcc_align      <= 1'b0;
      self_align_en  <= 1'b1;
      manual_setting <= 2'b00;
      locked         <= 1'b0;
      failed         <= 1'b0;
      retryCnt       <= 2'd0;
      pulse_cnt      <= '0;
      settle_cnt     <= '0;
      timer          <= '0;
      win_cnt        <= '0;
      win_err        <= '0;
    end else if (forceRealign && state != IDLE) begin
      state          <= PULSE;
      fcc_align      <= 1'b1;
      self_align_en  <= 1'b1;
      manual_setting <= 2'b00;
      locked         <= 1'b0;
      failed         <= 1'b0;
      retryCnt       <= 2'd0;
      pulse_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          state          <= PULSE;
          fcc_align      <= 1'b1;
          self_align_en  <= 1'b1;
          manual_setting <= 2'b00;
          retryCnt       <= 2'd0;
          pulse_cnt      <= '0;
        end

        PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            state      <= WAIT_LOCK;
            fcc_align  <= 1'b0;
            timer      <= '0;
            settle_cnt <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end

        // A completed settle count takes priority over a coinciding timeout.
        WAIT_LOCK: begin
          timer      <= timer + TW'(1);
          settle_cnt <= aligned ? settle_cnt + SW'(1) : '0;
          if (aligned && settle_cnt == SETTLE_LAST) begin
            state   <= LOCKED;
            locked  <= 1'b1;
            win_cnt <= '0;
            win_err <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            if (self_align_en || manual_setting != 2'b11) begin
              state     <= PULSE;
              fcc_align <= 1'b1;
              pulse_cnt <= '0;
            end else begin
              state  <= FAILED;
              failed <= 1'b1;
            end
            if (self_align_en) begin
              if (retryCnt < RETRY_MAX) begin
                retryCnt <= retryCnt + 2'd1;
              end else begin
                self_align_en  <= 1'b0;
                manual_setting <= 2'b00;
              end
            end else if (manual_setting != 2'b11) begin
              manual_setting <= manual_setting + 2'd1;
            end
          end
        end

        LOCKED: begin
          if (invalid_cmd && errCnt != 8'hFF) begin
            errCnt <= errCnt + 8'd1;
          end
          win_cnt <= win_wrap ? '0 : win_cnt + WW'(1);
          if (win_wrap) begin
            win_err <= '0;
          end else if (invalid_cmd) begin
            win_err <= win_err + EW'(1);
          end
          if (!aligned || err_hit) begin
            state     <= PULSE;
            fcc_align <= 1'b1;
            locked    <= 1'b0;
            pulse_cnt <= '0;
          end
        end

        FAILED: begin
          state <= FAILED;
        end

        default: begin
          state     <= IDLE;
          fcc_align <= 1'b0;
          locked    <= 1'b0;
          failed    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_align_sequencer.sv
// Directed bench for fc_align_sequencer: lock, retry/manual scan, error windows, overrides.
module tb_fc_align_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PULSE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_FAILED = 3'd4;

  logic       clk40 = 1'b0;
  logic       reset;
  logic       enable;
  logic       forceRealign;
  logic       locked;
  logic       failed;
  logic [2:0] state;
  logic [1:0] retryCnt;
  logic [7:0] errCnt;
  logic [10:0] status;

  int vectors = 0;
  int miscompares = 0;

  fc_align_sequencer_if dec();

  fc_align_sequencer #(
    .PULSE_LEN(4), .SETTLE(64), .LOCK_TIMEOUT(1024),
    .MAX_RETRY(3), .ERR_WINDOW(256), .ERR_THRESH(4)
  ) dut (
    .clk40(clk40),
    .reset(reset),
    .enable(enable),
    .forceRealign(forceRealign),
    .dec(dec),
    .locked(locked),
    .failed(failed),
    .state(state),
    .retryCnt(retryCnt),
    .errCnt(errCnt)
  );

  always #5 clk40 = ~clk40;

  assign status = {state, dec.fccAlign, dec.selfAlignEn, dec.clkDelayEn, dec.fcDelayEn,
                   locked, failed, retryCnt};

  function automatic logic [10:0] expStatus(input logic [2:0] st, input logic fcc,
                                            input logic self, input logic [1:0] dly,
                                            input logic lk, input logic fl,
                                            input logic [1:0] rc);
    return {st, fcc, self, dly, lk, fl, rc};
  endfunction

  task automatic applyStimulus(input logic en, input logic frc, input logic al,
                               input logic inv, input int cycles);
    enable         = en;
    forceRealign   = frc;
    dec.aligned    = al;
    dec.invalidCmd = inv;
    repeat (cycles) begin
      @(posedge clk40);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One failed attempt with aligned held low: attempt index picks the expected mode/setting.
  task automatic runAttempt(input int a);
    logic       self;
    logic [1:0] rc;
    logic [1:0] dly;
    self = (a < 4);
    rc   = (a < 4) ? 2'(a) : 2'd3;
    dly  = (a < 4) ? 2'd0 : 2'(a - 4);
    checkOutput($sformatf("attempt%0d entry", a), 16'(status),
                16'(expStatus(S_PULSE, 1'b1, self, dly, 1'b0, 1'b0, rc)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    checkOutput($sformatf("attempt%0d pulse", a), 16'(status),
                16'(expStatus(S_PULSE, 1'b1, self, dly, 1'b0, 1'b0, rc)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput($sformatf("attempt%0d wait", a), 16'(status),
                16'(expStatus(S_WAIT, 1'b0, self, dly, 1'b0, 1'b0, rc)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1023);
    checkOutput($sformatf("attempt%0d pre-timeout", a), 16'(status),
                16'(expStatus(S_WAIT, 1'b0, self, dly, 1'b0, 1'b0, rc)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
  endtask

  initial begin
    int e;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("reset status", 16'(status),
                16'(expStatus(S_IDLE, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0)));
    checkOutput("reset errCnt", 16'(errCnt), 16'd0);

    // Basic lock: pulse of four cycles, aligned rises ten cycles later, lock at +74.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("t1 pulse start", 16'(status),
                16'(expStatus(S_PULSE, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("t1 pulse 4th", 16'(dec.fccAlign), 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("t1 pulse end", 16'(status),
                16'(expStatus(S_WAIT, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 63);
    checkOutput("t1 end+73", 16'(locked), 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("t1 end+74", 16'(status),
                16'(expStatus(S_LOCKED, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0)));

    // Four invalid commands in one window force a re-align; relock after 64 aligned cycles.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3);
    checkOutput("t3 three errs", 16'({state, errCnt}), 16'({S_LOCKED, 8'd3}));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1);
    checkOutput("t3 realign", 16'(status),
                16'(expStatus(S_PULSE, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0)));
    checkOutput("t3 errCnt 4", 16'(errCnt), 16'd4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4);
    checkOutput("t3 wait", 16'(state), 16'(S_WAIT));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 63);
    checkOutput("t3 pre-relock", 16'(state), 16'(S_WAIT));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("t3 relock", 16'(state), 16'(S_LOCKED));

    // Three errors per window never re-align; errCnt climbs then saturates.
    for (int w = 1; w <= 85; w++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 253);
      e = 4 + 3 * w;
      if (e > 255) e = 255;
      checkOutput($sformatf("t3 window%0d", w), 16'({locked, errCnt}), 16'({1'b1, 8'(e)}));
    end

    // forceRealign from LOCKED, then a one-cycle glitch at settle count 63.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("t4 force", 16'(status),
                16'(expStatus(S_PULSE, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0)));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 63);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("t4 glitch", 16'(state), 16'(S_WAIT));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 63);
    checkOutput("t4 delayed", 16'(state), 16'(S_WAIT));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("t4 lock", 16'(status),
                16'(expStatus(S_LOCKED, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2'd0)));
    checkOutput("t4 errCnt kept", 16'(errCnt), 16'd255);

    // aligned drop re-aligns, then aligned never returns: four self, four manual, FAILED.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    for (int a = 0; a < 8; a++) begin
      runAttempt(a);
    end
    checkOutput("t2 failed", 16'(status),
                16'(expStatus(S_FAILED, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 2'd3)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10);
    checkOutput("t5 failed hold", 16'(status),
                16'(expStatus(S_FAILED, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 2'd3)));

    // forceRealign out of FAILED restarts in self mode.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    forceRealign = 1'b0;
    for (int a = 0; a < 5; a++) begin
      runAttempt(a);
    end
    checkOutput("t6 manual01", 16'(status),
                16'(expStatus(S_PULSE, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'd3)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 104);
    checkOutput("t6 mid wait", 16'(state), 16'(S_WAIT));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("t6 disable", 16'(status),
                16'(expStatus(S_IDLE, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0)));
    checkOutput("t6 disable errCnt", 16'(errCnt), 16'd255);

    // Reset in the middle of a pulse kills it on the same edge.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("t6 mid pulse", 16'(status),
                16'(expStatus(S_PULSE, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0)));
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("t6 reset status", 16'(status),
                16'(expStatus(S_IDLE, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0)));
    checkOutput("t6 reset errCnt", 16'(errCnt), 16'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("t6 restart", 16'(status),
                16'(expStatus(S_PULSE, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
